// File: rtl/cpu_pkg.sv
// Shared decode-stage types and constants: branch encodings, bus widths
// and a constant-foldable clog2 helper.
package cpu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int CTRL_W_DEF = 24;
  localparam int BR_W       = 3;
  localparam int CNT_W      = 32;

  typedef enum logic [BR_W-1:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_BL   = 3'd2,
    BR_BEQ  = 3'd3,
    BR_BNE  = 3'd4,
    BR_JIRL = 3'd5
  } br_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 32'd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) begin
        w = 32'(i) + 32'd1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_nr.sv
// Architectural register file: two combinational read ports, one write port,
// entry 0 hardwired to zero.
module regfile_nr
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [clog2(NREG)-1:0]   ra1,
  output logic [XLEN-1:0]          rd1,
  input  logic [clog2(NREG)-1:0]   ra2,
  output logic [XLEN-1:0]          rd2,
  input  logic                     we,
  input  logic [clog2(NREG)-1:0]   wa,
  input  logic [XLEN-1:0]          wd
);

  localparam int AW = clog2(NREG);

  logic [XLEN-1:0] regs_r [NREG];

  // Register storage; writes to index 0 are dropped so it always reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (wa != {AW{1'b0}})) begin
      regs_r[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[ra1];
  assign rd2 = (ra2 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[ra2];

endmodule

// File: rtl/id_stage_fwd.sv
// Decode/issue stage: one-entry pipeline register, EXE/MEM/WB operand
// forwarding with load-use and MEM-not-ready stalls, branch check and stall counter.
module id_stage_fwd
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ipd_valid,
  output logic                   id_allow_in,
  input  logic [XLEN-1:0]        ipd_pc,
  input  logic [XLEN-1:0]        ipd_pred_pc,
  input  logic [XLEN-1:0]        ipd_imm,
  input  logic [clog2(NREG)-1:0] ipd_rj,
  input  logic [clog2(NREG)-1:0] ipd_rk,
  input  logic [clog2(NREG)-1:0] ipd_rd,
  input  logic                   ipd_use_rj,
  input  logic                   ipd_use_rk,
  input  logic                   ipd_we,
  input  logic                   ipd_is_load,
  input  br_e                    ipd_br,
  input  logic [CTRL_W-1:0]      ipd_ctrl,
  input  logic                   exe_allow_in,
  output logic                   id_to_exe_valid,
  output logic [XLEN-1:0]        id_pc,
  output logic [XLEN-1:0]        id_rj_val,
  output logic [XLEN-1:0]        id_rk_val,
  output logic [XLEN-1:0]        id_imm,
  output logic [clog2(NREG)-1:0] id_rd,
  output logic                   id_we,
  output logic                   id_is_load,
  output logic [CTRL_W-1:0]      id_ctrl,
  input  logic                   exe_valid,
  input  logic                   exe_we,
  input  logic                   exe_is_load,
  input  logic [clog2(NREG)-1:0] exe_rd,
  input  logic [XLEN-1:0]        exe_data,
  input  logic                   mem_valid,
  input  logic                   mem_we,
  input  logic                   mem_data_ok,
  input  logic [clog2(NREG)-1:0] mem_rd,
  input  logic [XLEN-1:0]        mem_data,
  input  logic                   wb_we,
  input  logic [clog2(NREG)-1:0] wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   redirect_valid,
  output logic [XLEN-1:0]        redirect_pc,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int AW = clog2(NREG);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic              id_valid_r;
  logic [XLEN-1:0]   id_pc_r;
  logic [XLEN-1:0]   id_pred_pc_r;
  logic [XLEN-1:0]   id_imm_r;
  logic [AW-1:0]     id_rj_r;
  logic [AW-1:0]     id_rk_r;
  logic [AW-1:0]     id_rd_r;
  logic              id_use_rj_r;
  logic              id_use_rk_r;
  logic              id_we_r;
  logic              id_is_load_r;
  br_e               id_br_r;
  logic [CTRL_W-1:0] id_ctrl_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic [AW-1:0]     src_idx_s  [2];
  logic              src_use_s  [2];
  logic [XLEN-1:0]   rf_rdata_s [2];
  logic [XLEN-1:0]   opnd_s     [2];
  logic [1:0]        opnd_haz_s;

  logic              ready_go_s;
  logic              id_allow_in_s;
  logic              fire_s;
  logic              latch_s;
  logic              redirect_s;
  logic [XLEN-1:0]   pc_seq_s;
  logic [XLEN-1:0]   pc_imm_s;
  logic [XLEN-1:0]   target_s;

  regfile_nr #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (id_rj_r),
    .rd1   (rf_rdata_s[0]),
    .ra2   (id_rk_r),
    .rd2   (rf_rdata_s[1]),
    .we    (wb_we),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  assign src_idx_s[0] = id_rj_r;
  assign src_idx_s[1] = id_rk_r;
  assign src_use_s[0] = id_use_rj_r;
  assign src_use_s[1] = id_use_rk_r;

  // Operand resolution: EXE (non-load) > MEM > WB > register file; a load in
  // EXE or unready MEM data on the winning hit stalls the stage.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      opnd_s[i]     = rf_rdata_s[i];
      opnd_haz_s[i] = 1'b0;
      if (src_idx_s[i] == {AW{1'b0}}) begin
        opnd_s[i] = {XLEN{1'b0}};
      end else if (exe_valid && exe_we && (exe_rd == src_idx_s[i])) begin
        if (exe_is_load) begin
          opnd_haz_s[i] = src_use_s[i];
          if (mem_valid && mem_we && (mem_rd == src_idx_s[i])) begin
            opnd_s[i] = mem_data;
          end else if (wb_we && (wb_rd == src_idx_s[i])) begin
            opnd_s[i] = wb_data;
          end else begin
            opnd_s[i] = rf_rdata_s[i];
          end
        end else begin
          opnd_s[i] = exe_data;
        end
      end else if (mem_valid && mem_we && (mem_rd == src_idx_s[i])) begin
        opnd_s[i]     = mem_data;
        opnd_haz_s[i] = src_use_s[i] & ~mem_data_ok;
      end else if (wb_we && (wb_rd == src_idx_s[i])) begin
        opnd_s[i] = wb_data;
      end else begin
        opnd_s[i] = rf_rdata_s[i];
      end
    end
  end

  assign ready_go_s    = ~(|opnd_haz_s);
  assign id_allow_in_s = ~id_valid_r | (ready_go_s & exe_allow_in);
  assign fire_s        = id_valid_r & ready_go_s & exe_allow_in;
  assign pc_seq_s      = id_pc_r + PC_STEP;
  assign pc_imm_s      = id_pc_r + id_imm_r;

  // Branch target from the final operand values.
  always_comb begin
    target_s = pc_seq_s;
    case (id_br_r)
      BR_NONE: target_s = pc_seq_s;
      BR_B:    target_s = pc_imm_s;
      BR_BL:   target_s = pc_imm_s;
      BR_BEQ:  target_s = (opnd_s[0] == opnd_s[1]) ? pc_imm_s : pc_seq_s;
      BR_BNE:  target_s = (opnd_s[0] != opnd_s[1]) ? pc_imm_s : pc_seq_s;
      BR_JIRL: target_s = opnd_s[0] + id_imm_r;
      default: target_s = pc_seq_s;
    endcase
  end

  assign redirect_s = fire_s & (target_s != id_pred_pc_r);
  assign latch_s    = ipd_valid & id_allow_in_s & ~redirect_s;

  // Stage valid bit and latched instruction fields; a redirect flushes the
  // instruction arriving behind the mispredicted one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid_r   <= 1'b0;
      id_pc_r      <= {XLEN{1'b0}};
      id_pred_pc_r <= {XLEN{1'b0}};
      id_imm_r     <= {XLEN{1'b0}};
      id_rj_r      <= {AW{1'b0}};
      id_rk_r      <= {AW{1'b0}};
      id_rd_r      <= {AW{1'b0}};
      id_use_rj_r  <= 1'b0;
      id_use_rk_r  <= 1'b0;
      id_we_r      <= 1'b0;
      id_is_load_r <= 1'b0;
      id_br_r      <= BR_NONE;
      id_ctrl_r    <= {CTRL_W{1'b0}};
    end else begin
      if (redirect_s) begin
        id_valid_r <= 1'b0;
      end else if (id_allow_in_s) begin
        id_valid_r <= ipd_valid;
      end
      if (latch_s) begin
        id_pc_r      <= ipd_pc;
        id_pred_pc_r <= ipd_pred_pc;
        id_imm_r     <= ipd_imm;
        id_rj_r      <= ipd_rj;
        id_rk_r      <= ipd_rk;
        id_rd_r      <= ipd_rd;
        id_use_rj_r  <= ipd_use_rj;
        id_use_rk_r  <= ipd_use_rk;
        id_we_r      <= ipd_we;
        id_is_load_r <= ipd_is_load;
        id_br_r      <= ipd_br;
        id_ctrl_r    <= ipd_ctrl;
      end
    end
  end

  // Saturating count of cycles spent holding a stalled instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (id_valid_r && !ready_go_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign id_allow_in     = id_allow_in_s;
  assign id_to_exe_valid = id_valid_r & ready_go_s;
  assign id_pc           = id_pc_r;
  assign id_rj_val       = opnd_s[0];
  assign id_rk_val       = opnd_s[1];
  assign id_imm          = id_imm_r;
  assign id_rd           = id_rd_r;
  assign id_we           = id_we_r;
  assign id_is_load      = id_is_load_r;
  assign id_ctrl         = id_ctrl_r;
  assign redirect_valid  = redirect_s;
  assign redirect_pc     = id_valid_r ? target_s : {XLEN{1'b0}};
  assign stall_cnt       = stall_cnt_r;

endmodule
